// File: rtl/score_renderer.sv
// Score overlay: converts the binary score to BCD once per frame and renders
// four 24x24 ROM glyphs on the raster with leading-zero blanking.
module score_renderer #(
  parameter int X0      = 16,
  parameter int Y0      = 8,
  parameter int SPACING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score,
  input  logic        frame_start,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  output logic [3:0]  digit,
  output logic [9:0]  address,
  input  logic        rom_q,
  output logic        pixel_on,
  output logic        busy,
  output logic [1:0]  state_dbg   // 0 = IDLE, 1 = CONV, 2 = LOAD
);

  localparam int PITCH = 24 + SPACING;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [15:0] disp_q;

  // frame_start is a request accepted only while busy is low; a pulse seen
  // while busy is high is dropped, and busy falls once the display is updated.
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (frame_start) state_next = CONV;
      CONV: if (cnt == 4'd13) state_next = LOAD;
      LOAD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction applied before every shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      disp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            bin_q <= (score > 14'd9999) ? 14'd9999 : score;
            bcd_q <= '0;
            cnt   <= '0;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          cnt            <= (cnt == 4'd13) ? 4'd0 : cnt + 4'd1;
        end
        LOAD: disp_q <= bcd_q;
        default: ;
      endcase
    end
  end

  // Box 0 shows the thousands digit; each box is lit once any digit from
  // the left is nonzero, and the units box is always lit.
  logic [3:0] nz;
  logic [3:0] en;
  logic       in_rows;
  logic       hit;
  logic       box_en;
  logic [3:0] digit_c;
  logic [9:0] addr_c;
  logic [9:0] row;
  logic [9:0] col;
  logic       inbox_c;
  logic       inbox_d1;
  logic       inbox_d2;

  always_comb begin
    for (int k = 0; k < 4; k++) nz[k] = (disp_q[4*(3-k) +: 4] != 4'd0);
    en[0] = nz[0];
    en[1] = en[0] | nz[1];
    en[2] = en[1] | nz[2];
    en[3] = 1'b1;
  end

  assign in_rows = (vcount >= 10'(Y0)) && (vcount < 10'(Y0 + 24));
  assign row     = vcount - 10'(Y0);

  always_comb begin
    hit     = 1'b0;
    box_en  = 1'b0;
    digit_c = '0;
    addr_c  = '0;
    col     = '0;
    for (int k = 0; k < 4; k++) begin
      if (in_rows && (hcount >= 10'(X0 + k*PITCH)) && (hcount < 10'(X0 + k*PITCH + 24))) begin
        hit     = 1'b1;
        box_en  = en[k];
        digit_c = disp_q[4*(3-k) +: 4];
        col     = hcount - 10'(X0 + k*PITCH);
        addr_c  = (row * 10'd24) + col;
      end
    end
  end

  assign inbox_c = video_on & hit & box_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit    <= '0;
      address  <= '0;
      inbox_d1 <= 1'b0;
      inbox_d2 <= 1'b0;
    end else begin
      digit    <= digit_c;
      address  <= addr_c;
      inbox_d1 <= inbox_c;
      inbox_d2 <= inbox_d1;
    end
  end

  // rom_q arrives one clock after the address, aligned with inbox_d2.
  assign pixel_on = rom_q & inbox_d2;

endmodule
